// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters.
// Define UART_ARB_BURST_EN to let a still-valid winner keep the grant for up to MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_parity_en,
  input  logic [NUM_REQ-1:0]             req_parity_odd,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           arb_busy,
  output logic                           tx_enb,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_parity_en,
  output logic                           tx_parity_odd,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [15:0]                    byte_count
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        pointer_q, pointer_d;
  logic [PtrW-1:0]        win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   tx_enb_q, tx_enb_d;
  logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
  logic                   tx_parity_en_q, tx_parity_en_d;
  logic                   tx_parity_odd_q, tx_parity_odd_d;
  logic [15:0]            byte_count_q, byte_count_d;

  logic [PtrW-1:0]        winner;
  logic [PtrW-1:0]        idx_w;
  logic [NUM_REQ-1:0]     winner_oh;
  logic [PtrW-1:0]        next_ptr;
  logic                   found;
  logic                   accept;
  int unsigned            idx;

`ifdef UART_ARB_BURST_EN
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  logic [BurstW-1:0]      burst_cnt_q, burst_cnt_d;
`else
  // Burst length only matters when bursting is compiled in.
  if (MAX_BURST == 0) begin : g_max_burst_unused
  end
`endif

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(pointer_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PtrW'(idx);
      if (!found && req_valid[idx_w]) begin
        winner = idx_w;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  assign req_ready = (state_q == StIdle && !reset && !tx_busy && |req_valid) ? winner_oh : '0;
  assign accept    = |(req_valid & req_ready);
  assign next_ptr  = (win_idx_q == PtrW'(NUM_REQ - 1)) ? '0 : win_idx_q + PtrW'(1);

  always_comb begin
    state_d         = state_q;
    pointer_d       = pointer_q;
    win_idx_d       = win_idx_q;
    grant_d         = grant_q;
    tx_enb_d        = 1'b0;
    tx_data_d       = tx_data_q;
    tx_parity_en_d  = tx_parity_en_q;
    tx_parity_odd_d = tx_parity_odd_q;
    byte_count_d    = byte_count_q;
`ifdef UART_ARB_BURST_EN
    burst_cnt_d     = burst_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_data_d       = req_data[32'(winner) * DATA_BITS +: DATA_BITS];
          tx_parity_en_d  = req_parity_en[winner];
          tx_parity_odd_d = req_parity_odd[winner];
          grant_d         = winner_oh;
          win_idx_d       = winner;
          tx_enb_d        = 1'b1;
          state_d         = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (tx_done) begin
          byte_count_d = byte_count_q + 16'd1;
          grant_d      = '0;
          state_d      = StIdle;
`ifdef UART_ARB_BURST_EN
          if (req_valid[win_idx_q] && (32'(burst_cnt_q) + 1 < MAX_BURST)) begin
            pointer_d   = win_idx_q;
            burst_cnt_d = burst_cnt_q + BurstW'(1);
          end else begin
            pointer_d   = next_ptr;
            burst_cnt_d = '0;
          end
`else
          pointer_d    = next_ptr;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      pointer_q       <= '0;
      win_idx_q       <= '0;
      grant_q         <= '0;
      tx_enb_q        <= 1'b0;
      tx_data_q       <= '0;
      tx_parity_en_q  <= 1'b0;
      tx_parity_odd_q <= 1'b0;
      byte_count_q    <= '0;
`ifdef UART_ARB_BURST_EN
      burst_cnt_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      pointer_q       <= pointer_d;
      win_idx_q       <= win_idx_d;
      grant_q         <= grant_d;
      tx_enb_q        <= tx_enb_d;
      tx_data_q       <= tx_data_d;
      tx_parity_en_q  <= tx_parity_en_d;
      tx_parity_odd_q <= tx_parity_odd_d;
      byte_count_q    <= byte_count_d;
`ifdef UART_ARB_BURST_EN
      burst_cnt_q     <= burst_cnt_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign arb_busy      = (state_q != StIdle);
  assign tx_enb        = tx_enb_q;
  assign tx_data       = tx_data_q;
  assign tx_parity_en  = tx_parity_en_q;
  assign tx_parity_odd = tx_parity_odd_q;
  assign byte_count    = byte_count_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx instance between NUM_REQ independent byte requesters.
- Accepts one byte per grant over a valid/ready handshake and latches that requester's data and parity settings.
- Pulses the transmitter's tx_enb, waits for its done, then rotates priority.
- Sits between several client FIFOs/engines and the single UART_Tx pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, byte width; matches the uart_tx DATA_BITS parameter
MAX_BURST, 4, max consecutive bytes per grant; used only when UART_ARB_BURST_EN is defined

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte
req_data  in  NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS]
req_parity_en  in  NUM_REQ  parity enable for requester i's byte
req_parity_odd  in  NUM_REQ  parity select for requester i's byte (same encoding as uart_tx parity_odd)
req_ready  out  NUM_REQ  one-hot combinational accept; transfer when req_valid[i] and req_ready[i] are both high at a rising edge
grant  out  NUM_REQ  one-hot owner of the transmitter, registered
arb_busy  out  1  high whenever state is not IDLE
tx_enb  out  1  start pulse to uart_tx
tx_data  out  DATA_BITS  latched byte to uart_tx
tx_parity_en  out  1  latched parity enable to uart_tx
tx_parity_odd  out  1  latched parity select to uart_tx
tx_busy  in  1  uart_tx busy
tx_done  in  1  uart_tx done pulse
byte_count  out  16  bytes completed since reset, wraps

Behaviour:
- Reset, sampled at clock edge:
  - state=IDLE, pointer=0; burst_cnt=0 when UART_ARB_BURST_EN is defined.
  - Outputs: grant=0, tx_enb=0, tx_data=0, tx_parity_en=0, tx_parity_odd=0, byte_count=0.
  - req_ready=0 and arb_busy=0 follow from state=IDLE with no eligible request.
- Reset asserted mid-operation aborts immediately. The uart_tx frame is not cancelled by this block.
- Winner (combinational): the first i with req_valid[i]=1, searching pointer, pointer+1, ... modulo NUM_REQ.
- States:
  - IDLE:
    - req_ready = onehot(winner) only if state==IDLE, tx_busy==0 and req_valid!=0; otherwise req_ready=0.
    - On the transfer edge: latch req_data[winner] into tx_data, and req_parity_en/req_parity_odd[winner] into tx_parity_en/tx_parity_odd.
    - Same edge: grant<=onehot(winner), win_idx<=winner, go to START.
  - START:
    - tx_enb=1 for exactly this one cycle (registered), then go to WAIT.
    - tx_done is ignored in this state.
  - WAIT:
    - tx_enb=0; hold tx_data and the parity outputs.
    - On tx_done=1: byte_count<=byte_count+1, grant<=0, pointer<=(win_idx+1) mod NUM_REQ, go to IDLE.
- Latency:
  - Transfer edge k: tx_enb high in cycle k+1.
  - Minimum spacing between transfers: 3 cycles plus the UART frame time.
- Boundaries:
  - req_valid dropped before transfer: no acceptance, no state change.
  - req_valid/req_data changes after transfer have no effect on the latched byte.
  - Pointer wraps from NUM_REQ-1 to 0; byte_count wraps from 0xFFFF to 0x0000.
  - tx_busy high in IDLE (transmitter owned externally): no req_ready, remain in IDLE.
  - A single requester held valid is granted every round.
  - tx_done and a new req_valid in the same WAIT cycle: the new request is eligible in the following IDLE cycle, arbitrated with the updated pointer.
- At most one grant bit is ever set.

Optional Feature:
- Macro: UART_ARB_BURST_EN.
- Defined: in WAIT on tx_done:
  - If req_valid[win_idx]=1 and burst_cnt<MAX_BURST-1: pointer<=win_idx and burst_cnt<=burst_cnt+1, so the same requester wins the next IDLE.
  - Otherwise: pointer<=win_idx+1 and burst_cnt<=0.
- Not defined: always rotate; MAX_BURST has no effect and the burst_cnt register is not present.

Test Plan:
- Reset: assert reset 2 cycles with req_valid=4'hF -> grant=0, tx_enb=0, req_ready=0, byte_count=0, arb_busy=0.
- Single byte: req_valid=4'b0001, req_data[7:0]=8'hA5, parity_en=1, parity_odd=0.
  - req_ready=4'b0001 in IDLE.
  - Next cycle: tx_enb=1, tx_data=8'hA5, tx_parity_en=1, grant=4'b0001.
  - After tx_done: grant=0, byte_count=1.
- Fairness: req_valid=4'hF held, 5 bytes -> grant order 0,1,2,3,0; byte_count=5; no grant overlap.
- Skip/wrap: pointer=2, req_valid=4'b1010 -> requester 3 served, then requester 1 (pointer wraps 3->0, selects 1).
- Blocking and abort:
  - tx_busy forced 1 in IDLE with req_valid=4'h1 -> req_ready=0 for 10 cycles.
  - Reset pulsed in WAIT -> next edge grant=0, tx_enb=0, pointer=0, byte_count=0.
- Burst (UART_ARB_BURST_EN, MAX_BURST=2): req_valid=4'b0011 held -> grant order 0,0,1,1,0.
  - Same stimulus without the macro -> grant order 0,1,0,1.
